// File: rtl/l1_tag_lookup_ctrl.sv
// l1_tag_lookup_ctrl: lookup/refill controller for the L1 tag+valid RAM.
// Splits a request address into {tag, idx, off}, reads the tag RAM at the accept
// edge, compares in LOOKUP, and on a miss handshakes a block refill with the next
// level before writing {tag, valid} back. Sweeps every entry to invalid after
// reset and on a flush.
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   req_*                  core request (valid/ready, byte address)
//   flush_i                invalidate-all request, honoured in IDLE
//   resp_*                 one-cycle lookup result (hit flag, line index)
//   mem_req_*              refill request to the next level
//   mem_resp_valid_i       refill delivered pulse
//   tgv_*                  tag RAM port (1-cycle sync read, write data {tag,valid})
//   busy_o                 controller not idle
module l1_tag_lookup_ctrl #(
  parameter int unsigned TAG_W = 9,
  parameter int unsigned IDX_W = 6,
  parameter int unsigned OFF_W = 4,
  localparam int unsigned ADDR_W = TAG_W + IDX_W + OFF_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [ADDR_W-1:0]      req_addr_i,
  input  logic                   flush_i,
  output logic                   resp_valid_o,
  output logic                   resp_hit_o,
  output logic [IDX_W-1:0]       resp_idx_o,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic [TAG_W+IDX_W-1:0] mem_req_addr_o,
  input  logic                   mem_resp_valid_i,
  output logic                   tgv_we_o,
  output logic [IDX_W-1:0]       tgv_addr_o,
  output logic [TAG_W:0]         tgv_data_o,
  input  logic [TAG_W:0]         tgv_data_i,
  output logic                   busy_o
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS_REQ,
    ST_MISS_WAIT,
    ST_FILL,
    ST_RESP,
    ST_FLUSH
  } state_e;

  state_e           state;
  logic [IDX_W-1:0] cnt;
  logic [TAG_W-1:0] tag_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] tgv_addr_q;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] unused_off;
  logic             lookup_hit;

  // Address split; the byte offset is irrelevant to the tag array.
  assign req_tag    = req_addr_i[ADDR_W-1 -: TAG_W];
  assign req_idx    = req_addr_i[OFF_W +: IDX_W];
  assign unused_off = req_addr_i[OFF_W-1:0];

  // Entry matches when valid and the stored tag equals the latched tag.
  assign lookup_hit = tgv_data_i[0] && (tgv_data_i[TAG_W:1] == tag_q);

  // A held flush blocks acceptance so flush always wins over a request.
  assign req_ready_o = (state == ST_IDLE) && !flush_i;

  // In IDLE the RAM address follows the request so the read launches at the accept edge.
  assign tgv_addr_o = (state == ST_IDLE) ? req_idx : tgv_addr_q;

  // Control FSM; every output register holds the value for the state being entered.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state           <= ST_INIT;
      cnt             <= '0;
      tag_q           <= '0;
      idx_q           <= '0;
      tgv_addr_q      <= '0;
      tgv_we_o        <= 1'b0;
      tgv_data_o      <= '0;
      mem_req_valid_o <= 1'b0;
      mem_req_addr_o  <= '0;
      resp_valid_o    <= 1'b0;
      resp_hit_o      <= 1'b0;
      resp_idx_o      <= '0;
      busy_o          <= 1'b1;
    end else begin
      resp_valid_o <= 1'b0;
      resp_hit_o   <= 1'b0;
      resp_idx_o   <= '0;
      case (state)
        ST_INIT, ST_FLUSH: begin
          // After reset the write enable is still low: start presenting entry cnt.
          if (!tgv_we_o) begin
            tgv_we_o   <= 1'b1;
            tgv_addr_q <= cnt;
            tgv_data_o <= '0;
          end else if (&cnt) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            tgv_we_o   <= 1'b0;
            tgv_addr_q <= '0;
            busy_o     <= 1'b0;
          end else begin
            cnt        <= cnt + IDX_W'(1);
            tgv_addr_q <= cnt + IDX_W'(1);
          end
        end
        ST_IDLE: begin
          if (flush_i) begin
            state      <= ST_FLUSH;
            busy_o     <= 1'b1;
            cnt        <= '0;
            tgv_we_o   <= 1'b1;
            tgv_addr_q <= '0;
            tgv_data_o <= '0;
          end else if (req_valid_i) begin
            state      <= ST_LOOKUP;
            busy_o     <= 1'b1;
            tag_q      <= req_tag;
            idx_q      <= req_idx;
            tgv_addr_q <= req_idx;
          end
        end
        ST_LOOKUP: begin
          if (lookup_hit) begin
            state        <= ST_RESP;
            resp_valid_o <= 1'b1;
            resp_hit_o   <= 1'b1;
            resp_idx_o   <= idx_q;
          end else begin
            state           <= ST_MISS_REQ;
            mem_req_valid_o <= 1'b1;
            mem_req_addr_o  <= {tag_q, idx_q};
          end
        end
        ST_MISS_REQ: begin
          if (mem_req_ready_i) begin
            state           <= ST_MISS_WAIT;
            mem_req_valid_o <= 1'b0;
            mem_req_addr_o  <= '0;
          end
        end
        ST_MISS_WAIT: begin
          if (mem_resp_valid_i) begin
            state      <= ST_FILL;
            tgv_we_o   <= 1'b1;
            tgv_addr_q <= idx_q;
            tgv_data_o <= {tag_q, 1'b1};
          end
        end
        ST_FILL: begin
          state        <= ST_RESP;
          tgv_we_o     <= 1'b0;
          tgv_data_o   <= '0;
          resp_valid_o <= 1'b1;
          resp_hit_o   <= 1'b0;
          resp_idx_o   <= idx_q;
        end
        ST_RESP: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state    <= ST_INIT;
          cnt      <= '0;
          tgv_we_o <= 1'b0;
          busy_o   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_tag_lookup_ctrl.sv
// Testbench for l1_tag_lookup_ctrl: tag RAM and next-level models plus a
// reference model of the cache's valid/tag contents.
module tb_l1_tag_lookup_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [18:0] req_addr;
  logic        flush;
  logic        resp_valid;
  logic        resp_hit;
  logic [5:0]  resp_idx;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [14:0] mem_req_addr;
  logic        mem_resp_valid;
  logic        tgv_we;
  logic [5:0]  tgv_addr;
  logic [9:0]  tgv_wdata;
  logic [9:0]  tgv_rdata;
  logic        busy;

  always #5 clk = ~clk;

  l1_tag_lookup_ctrl dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_addr_i       (req_addr),
    .flush_i          (flush),
    .resp_valid_o     (resp_valid),
    .resp_hit_o       (resp_hit),
    .resp_idx_o       (resp_idx),
    .mem_req_valid_o  (mem_req_valid),
    .mem_req_ready_i  (mem_req_ready),
    .mem_req_addr_o   (mem_req_addr),
    .mem_resp_valid_i (mem_resp_valid),
    .tgv_we_o         (tgv_we),
    .tgv_addr_o       (tgv_addr),
    .tgv_data_o       (tgv_wdata),
    .tgv_data_i       (tgv_rdata),
    .busy_o           (busy)
  );

  // Tag RAM: 64 x 10, one-cycle synchronous read, read-first.
  logic [9:0] ram [64];
  always @(posedge clk) begin
    tgv_rdata <= ram[tgv_addr];
    if (tgv_we) ram[tgv_addr] <= tgv_wdata;
  end

  // Reference model: what the cache should currently hold per index.
  bit         mv [64];
  logic [8:0] mt [64];

  int checks = 0;
  int errors = 0;

  task automatic model_clear();
    for (int i = 0; i < 64; i++) mv[i] = 1'b0;
  endtask

  // Expects the 64-entry invalidation sweep, then an idle, ready controller.
  task automatic check_sweep(input bit wait_first);
    for (int i = 0; i < 64; i++) begin
      if (wait_first || i > 0) @(negedge clk);
      checks++;
      if (!(tgv_we === 1'b1 && tgv_addr === 6'(i) && tgv_wdata === 10'd0 &&
            busy === 1'b1 && req_ready === 1'b0)) begin
        errors++;
        $display("FAIL sweep[%0d]: we=%b addr=%0d data=%h busy=%b rdy=%b, want we=1 addr=%0d data=0 busy=1 rdy=0",
                 i, tgv_we, tgv_addr, tgv_wdata, busy, req_ready, i);
      end
    end
    @(negedge clk);
    checks++;
    if (!(busy === 1'b0 && tgv_we === 1'b0 && req_ready === 1'b1)) begin
      errors++;
      $display("FAIL sweep_exit: busy=%b we=%b rdy=%b, want 0 0 1", busy, tgv_we, req_ready);
    end
  endtask

  // One complete request; next level asserts ready after rdy_wait cycles of valid,
  // delivers data rsp_wait cycles into MISS_WAIT; early adds a pulse alongside ready.
  task automatic run_req(input logic [18:0] addr, input int rdy_wait, input int rsp_wait, input bit early);
    logic [8:0] tag;
    logic [5:0] idx;
    bit exp_hit, rdy_done, rsp_sent, done;
    int k, n, mreq_cycles, rsp_cnt, fills;
    tag = addr[18:10];
    idx = addr[9:4];
    exp_hit = mv[idx] && (mt[idx] == tag);
    rdy_done = 0; rsp_sent = 0; done = 0;
    mreq_cycles = 0; rsp_cnt = 0; fills = 0;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait: req_ready=%b after %0d cycles, want 1", req_ready, n);
    end
    req_valid = 1'b1;
    req_addr  = addr;
    @(posedge clk);
    k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL inflight_busy k=%0d: busy=%b rdy=%b, want 1 0", k, busy, req_ready);
      end
      if (tgv_we === 1'b1) begin
        fills++;
        checks++;
        if (!rsp_sent || tgv_addr !== idx || tgv_wdata !== {tag, 1'b1}) begin
          errors++;
          $display("FAIL fill_write: sent=%0d addr=%h data=%h, want sent=1 addr=%h data=%h",
                   rsp_sent, tgv_addr, tgv_wdata, idx, {tag, 1'b1});
        end
      end
      if (mem_req_valid === 1'b1) begin
        mreq_cycles++;
        checks++;
        if (mem_req_addr !== {tag, idx}) begin
          errors++;
          $display("FAIL mem_req_addr: got %h want %h", mem_req_addr, {tag, idx});
        end
        if (mreq_cycles == rdy_wait + 1) begin
          mem_req_ready = 1'b1;
          rdy_done = 1;
          if (early) mem_resp_valid = 1'b1;
        end
      end else if (rdy_done && !rsp_sent) begin
        if (rsp_cnt == rsp_wait) begin mem_resp_valid = 1'b1; rsp_sent = 1; end
        rsp_cnt++;
      end
      if (resp_valid === 1'b1) begin
        done = 1;
        checks++;
        if (resp_hit !== exp_hit || resp_idx !== idx) begin
          errors++;
          $display("FAIL resp: hit=%b idx=%h, want hit=%b idx=%h", resp_hit, resp_idx, exp_hit, idx);
        end
        if (exp_hit) begin
          checks++;
          // k+1 = posedges from the accept edge to the edge that captures resp_valid.
          if (k + 1 != 2) begin
            errors++;
            $display("FAIL hit_latency: got %0d want 2", k + 1);
          end
        end
      end
      if (!done) begin @(posedge clk); k++; end
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL resp_timeout: no resp_valid within %0d cycles, want one", k);
    end
    checks++;
    if (fills != (exp_hit ? 0 : 1) || mreq_cycles != (exp_hit ? 0 : rdy_wait + 1)) begin
      errors++;
      $display("FAIL miss_traffic: fills=%0d mreq_cycles=%0d, want %0d %0d",
               fills, mreq_cycles, exp_hit ? 0 : 1, exp_hit ? 0 : rdy_wait + 1);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || resp_hit !== 1'b0 || resp_idx !== 6'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL resp_pulse_end: valid=%b hit=%b idx=%h busy=%b, want 0 0 0 0",
               resp_valid, resp_hit, resp_idx, busy);
    end
    if (!exp_hit) begin mv[idx] = 1'b1; mt[idx] = tag; end
    checks++;
    if (ram[idx] !== {tag, 1'b1}) begin
      errors++;
      $display("FAIL ram_entry[%h]: got %h want %h", idx, ram[idx], {tag, 1'b1});
    end
  endtask

  // Flush from IDLE, optionally racing a request that must not be accepted.
  task automatic do_flush(input bit with_req, input logic [18:0] addr);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    flush = 1'b1;
    req_valid = with_req;
    req_addr = addr;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: req_ready=%b want 0", req_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    req_valid = 1'b0;
    check_sweep(0);
    model_clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL reset_busy: got %b want 1", busy);
    end
    checks++;
    if ({tgv_we, mem_req_valid, resp_valid, resp_hit, req_ready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: we=%b mreq=%b rv=%b rh=%b rdy=%b, want all 0",
               tgv_we, mem_req_valid, resp_valid, resp_hit, req_ready);
    end
    checks++;
    if (tgv_addr !== 6'd0 || tgv_wdata !== 10'd0 || resp_idx !== 6'd0 || mem_req_addr !== 15'd0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h ridx=%h maddr=%h, want all 0",
               tgv_addr, tgv_wdata, resp_idx, mem_req_addr);
    end
    rst_n = 1'b1;
    check_sweep(1);
    model_clear();
  endtask

  // Reset during MISS_WAIT (v=0) and during MISS_REQ (v=1).
  task automatic test_reset_midrefill();
    logic [18:0] addr;
    int n;
    for (int v = 0; v < 2; v++) begin
      addr = {9'(9'h155 + v), 6'h2A, 4'h0};
      n = 0;
      while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      req_valid = 1'b1; req_addr = addr;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (mem_req_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (mem_req_valid !== 1'b1) begin
        errors++; $display("FAIL midrefill_mreq: mem_req_valid=%b want 1", mem_req_valid);
      end
      if (v == 0) begin
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
      end
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_req_valid !== 1'b0 || resp_valid !== 1'b0 || tgv_we !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL midrefill_reset v=%0d: mreq=%b rv=%b we=%b busy=%b, want 0 0 0 1",
                 v, mem_req_valid, resp_valid, tgv_we, busy);
      end
      rst_n = 1'b1;
      check_sweep(1);
      model_clear();
    end
  endtask

  task automatic test_directed();
    run_req(19'h12340, 0, 0, 0);                  // cold miss
    run_req(19'h12340, 0, 0, 0);                  // same line hits
    run_req(19'h1234F, 0, 0, 0);                  // offset does not matter
    run_req({9'h1FF, 6'h34, 4'h0}, 5, 2, 1);      // conflict miss, stalled ready, early pulse
    run_req(19'h12340, 1, 0, 0);                  // evicted line misses again
    run_req(19'h12340, 0, 0, 0);
  endtask

  task automatic test_flush();
    do_flush(1'b1, 19'h12340);
    run_req(19'h12340, 0, 1, 0);                  // previously valid tag now misses
    run_req(19'h12340, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [8:0]  tags [4];
    logic [18:0] addr;
    tags[0] = 9'h000; tags[1] = 9'h1FF; tags[2] = 9'h0A5; tags[3] = 9'(9'h100 + $urandom_range(0, 63));
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 14) == 0) begin
        do_flush(1'($urandom_range(0, 1)), 19'($urandom));
      end else begin
        addr = {tags[$urandom_range(0, 3)], 6'($urandom_range(0, 7) * 9), 4'($urandom)};
        run_req(addr, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    test_reset();
    test_reset_midrefill();
    test_directed();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

endmodule
